cic_3_interpolator: RTL

- Third-order CIC interpolation filter: the transmit-direction counterpart of the cic_3_filter decimator.
- Accepts one signed low-rate sample every M clocks and produces one signed full-rate sample every clock.
- Sits between baseband I or Q generation and the high-rate I/Q upconversion path; one instance per channel.
- Runs on the single high-rate clock only; the low-rate side uses a valid/ready strobe, not a second clock.

---
 rtl/cic_3_interpolator.sv | 55 +++++
 1 files changed

// File: rtl/cic_3_interpolator.sv
// cic_3_interpolator: third-order CIC interpolator, one sample in every M clocks, one sample out every clock
module cic_3_interpolator #(
    parameter int M = 240,
    parameter int width = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic signed [width-1:0]              in,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic signed [width+$clog2(M**2)-1:0] out,
    output logic                                 out_valid,
    output logic                                 underrun
);
    localparam int W = width + $clog2(M**2);
    localparam int CW = $clog2(M);
    logic [CW-1:0] cnt;
    logic signed [W-1:0] x, c1, c2, c3, d1, d2, d3, c3_reg, u, i1, i2;
    logic [2:0] pend;
    assign in_ready = cnt == '0 && !reset;
    assign x = in_valid ? {{(W-width){in[width-1]}}, in} : '0;
    assign c1 = x - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;
    assign u = cnt == CW'(1) ? c3_reg : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            c3_reg <= '0;
            i1 <= '0;
            i2 <= '0;
            out <= '0;
            pend <= '0;
            out_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt <= cnt == CW'(M-1) ? '0 : cnt + 1'b1;
            if (in_ready) begin
                d1 <= x;
                d2 <= c1;
                d3 <= c2;
                c3_reg <= c3;
            end
            i1 <= i1 + u;
            i2 <= i2 + i1;
            out <= out + i2;
            pend <= {pend[1:0], in_ready};
            out_valid <= out_valid | pend[2];
            underrun <= in_ready && !in_valid;
        end
    end
endmodule
